fir_xifu_wb: RTL and testbench
==============================

Name: fir_xifu_wb

Overview:
Writeback stage of the FIR XIFU pipeline, directly downstream of the EX stage.
- Accepts EX-stage records (post-increment address, destination registers, load flag) into an in-order retire queue.
- Collects load data from the X-interface memory-result channel and tracks commit/kill per instruction id.
- Retires committed entries in order: next_addr goes to the core GPR via the X-interface result channel; load data goes to the internal FIR sample registers.

Parameters:
DEPTH, 4, retire-queue entries (power of two, ≥2)
ID_W, 4, X-interface instruction id width
XLEN, 32, data/address width
XREG_W, 3, internal FIR register index width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous reset, active-high
ex_valid_i  in  1  EX record valid
ex_ready_o  out  1  queue can accept
ex_id_i  in  ID_W  instruction id
ex_rd_i  in  5  core GPR destination
ex_gpr_we_i  in  1  instruction writes next_addr to GPR
ex_xd_i  in  XREG_W  internal FIR register destination
ex_load_i  in  1  instruction is a load (awaits mem result)
ex_next_addr_i  in  XLEN  post-increment address from EX
mem_result_valid_i  in  1  memory result valid
mem_result_id_i  in  ID_W  id of memory result
mem_result_rdata_i  in  XLEN  load data
commit_valid_i  in  1  commit strobe
commit_id_i  in  ID_W  committed id
commit_kill_i  in  1  instruction killed
result_valid_o  out  1  core result valid
result_ready_i  in  1  core accepts result
result_id_o  out  ID_W  result id
result_rd_o  out  5  GPR destination
result_we_o  out  1  GPR write enable
result_data_o  out  XLEN  next_addr value
xreg_we_o  out  1  internal register write pulse
xreg_addr_o  out  XREG_W  internal register index
xreg_wdata_o  out  XLEN  load data
pending_o  out  $clog2(DEPTH)+1  occupied entries
err_o  out  1  sticky: mem result with unmatched id

Behaviour:
Reset (rst_i high at a clock edge):
- Queue empties; commit table clears; err_o=0.
- All outputs 0, except ex_ready_o=1.
- Reset mid-operation discards all entries and any pending result handshake.

Commit table:
- 2^ID_W entries of {seen, kill}.
- commit_valid_i with no matching live queue entry sets seen[id] and kill[id]=commit_kill_i.
- A commit matching a live entry updates that entry directly.

Enqueue:
- Fires on ex_valid_i && ex_ready_o. ex_ready_o = (pending_o < DEPTH); it is low when full even if the head retires that cycle.
- New entry fields:
  - mem_done = !ex_load_i
  - committed = seen[ex_id_i] | (commit_valid_i && commit_id_i==ex_id_i)
  - killed likewise from kill / commit_kill_i
- The table slot for ex_id_i is cleared in the same cycle.

Memory result:
- mem_result_valid_i matches the oldest live, non-mem_done entry with equal id and load=1.
- On match: store rdata, set mem_done.
- No match: result ignored, err_o set sticky.
- A match against a killed entry is accepted silently.

Retire (head only, strictly in order):
- Killed head with mem_done (or load=0):
  - Dropped in one cycle.
  - No result, no xreg write.
  - Does not assert result_valid_o.
- Committed, non-killed head with mem_done:
  - result_valid_o=1 with id/rd/we/data from the entry.
  - Fields stay stable until result_ready_i.
  - On handshake: entry pops; if load, xreg_we_o pulses one cycle in the same cycle with xd and rdata.
- Otherwise result_valid_o=0.

Latency: record enqueued at cycle N with load=0, already committed → result_valid_o at N+1.

Simultaneous events:
- Enqueue and pop in the same cycle: pending_o unchanged.
- Commit and mem result for the same entry in the same cycle: both applied.
- Pointers wrap modulo DEPTH.

Optional Feature:
FIR_XIFU_WB_BYPASS_EN
- Defined: a zero-latency bypass applies when the queue is empty, ex_valid_i=1, ex_load_i=0, the id is committed (table or same-cycle) and not killed.
  - result_* are driven combinationally from ex_* in the same cycle.
  - If result_ready_i=1, the record is never enqueued.
  - If result_ready_i=0, the record enqueues normally.
- Undefined: no ex_*→result_* combinational path; minimum latency is 1 cycle.

Test Plan:
- Non-load, id=3, commit in the same cycle as enqueue, result_ready_i=1 → result_valid_o at N+1 with data=ex_next_addr_i (e.g. 0x1004); xreg_we_o=0.
- Load id=5, xd=2; commit at N+2; mem_result rdata=0xDEADBEEF at N+4 → single-cycle result handshake plus xreg_we_o pulse (addr=2, wdata=0xDEADBEEF) at N+5.
- Commit id=7 arrives 2 cycles before its EX record → entry enqueued as committed; retires at N+1; table slot 7 cleared.
- Fill DEPTH=4 with result_ready_i=0 → ex_ready_o=0 and pending_o=4; raise result_ready_i → 4 in-order results, ids preserved.
- Killed load id=1 ahead of non-load id=2, mem result for id=1 arrives → no result for id=1; id=2 retires; err_o=0.
- mem result with id=9 not in queue → err_o=1 until rst_i; assert rst_i mid-queue → pending_o=0 and result_valid_o=0 on the next cycle.

Source files
------------

// File: rtl/fir_xifu_wb.sv
// Writeback stage of the FIR XIFU pipeline: in-order retire queue with commit/kill tracking and load-data collection.
// Optional zero-latency bypass for committed non-loads into an empty queue: define FIR_XIFU_WB_BYPASS_EN.
module fir_xifu_wb #(
  parameter int DEPTH  = 4,
  parameter int ID_W   = 4,
  parameter int XLEN   = 32,
  parameter int XREG_W = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       ex_valid_i,
  output logic                       ex_ready_o,
  input  logic [ID_W-1:0]            ex_id_i,
  input  logic [4:0]                 ex_rd_i,
  input  logic                       ex_gpr_we_i,
  input  logic [XREG_W-1:0]          ex_xd_i,
  input  logic                       ex_load_i,
  input  logic [XLEN-1:0]            ex_next_addr_i,
  input  logic                       mem_result_valid_i,
  input  logic [ID_W-1:0]            mem_result_id_i,
  input  logic [XLEN-1:0]            mem_result_rdata_i,
  input  logic                       commit_valid_i,
  input  logic [ID_W-1:0]            commit_id_i,
  input  logic                       commit_kill_i,
  output logic                       result_valid_o,
  input  logic                       result_ready_i,
  output logic [ID_W-1:0]            result_id_o,
  output logic [4:0]                 result_rd_o,
  output logic                       result_we_o,
  output logic [XLEN-1:0]            result_data_o,
  output logic                       xreg_we_o,
  output logic [XREG_W-1:0]          xreg_addr_o,
  output logic [XLEN-1:0]            xreg_wdata_o,
  output logic [$clog2(DEPTH):0]     pending_o,
  output logic                       err_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NID   = 1 << ID_W;

  logic [ID_W-1:0]   q_id        [DEPTH];
  logic [4:0]        q_rd        [DEPTH];
  logic              q_we        [DEPTH];
  logic [XREG_W-1:0] q_xd        [DEPTH];
  logic              q_load      [DEPTH];
  logic [XLEN-1:0]   q_addr      [DEPTH];
  logic [XLEN-1:0]   q_rdata     [DEPTH];
  logic              q_mem_done  [DEPTH];
  logic              q_committed [DEPTH];
  logic              q_killed    [DEPTH];

  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  logic [NID-1:0]   seen, kill;
  logic             err;

  logic             new_committed, new_killed, accept, enq, pop;
  logic             head_ok, drop, q_rv, byp;
  logic             cm_hit, mr_hit;
  logic [PTR_W-1:0] cm_idx, mr_idx, idx;

  always_comb begin
    new_committed = seen[ex_id_i] | (commit_valid_i && commit_id_i == ex_id_i);
    new_killed    = kill[ex_id_i] | (commit_valid_i && commit_id_i == ex_id_i && commit_kill_i);
    ex_ready_o    = (count < CNT_W'(DEPTH));
    head_ok       = (count != '0) && q_mem_done[head] && q_committed[head];
    drop          = head_ok && q_killed[head];
    q_rv          = head_ok && !q_killed[head];
    pop           = drop || (q_rv && result_ready_i);
`ifdef FIR_XIFU_WB_BYPASS_EN
    byp = !rst_i && (count == '0) && ex_valid_i && !ex_load_i && new_committed && !new_killed;
`else
    byp = 1'b0;
`endif
    accept = ex_valid_i && ex_ready_o;
    enq    = accept && !(byp && result_ready_i);
  end

  // Oldest-first search for the live entry a commit or memory result belongs to
  always_comb begin
    cm_hit = 1'b0;
    mr_hit = 1'b0;
    cm_idx = '0;
    mr_idx = '0;
    idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (CNT_W'(k) < count) begin
        if (!cm_hit && q_id[idx] == commit_id_i && !q_committed[idx]) begin
          cm_hit = 1'b1;
          cm_idx = idx;
        end
        if (!mr_hit && q_id[idx] == mem_result_id_i && q_load[idx] && !q_mem_done[idx]) begin
          mr_hit = 1'b1;
          mr_idx = idx;
        end
      end
    end
  end

  always_comb begin
    result_valid_o = q_rv || byp;
    result_id_o    = '0;
    result_rd_o    = '0;
    result_we_o    = 1'b0;
    result_data_o  = '0;
    if (byp) begin
      result_id_o   = ex_id_i;
      result_rd_o   = ex_rd_i;
      result_we_o   = ex_gpr_we_i;
      result_data_o = ex_next_addr_i;
    end else if (q_rv) begin
      result_id_o   = q_id[head];
      result_rd_o   = q_rd[head];
      result_we_o   = q_we[head];
      result_data_o = q_addr[head];
    end
    xreg_we_o    = q_rv && !byp && result_ready_i && q_load[head];
    xreg_addr_o  = xreg_we_o ? q_xd[head] : '0;
    xreg_wdata_o = xreg_we_o ? q_rdata[head] : '0;
    pending_o    = count;
    err_o        = err;
  end

  // Control state: pointers, occupancy, commit table, sticky error
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      seen  <= '0;
      kill  <= '0;
      err   <= 1'b0;
    end else begin
      if (enq) tail <= tail + 1'b1;
      if (pop) head <= head + 1'b1;
      count <= count + CNT_W'(enq) - CNT_W'(pop);
      if (commit_valid_i && !cm_hit) begin
        seen[commit_id_i] <= 1'b1;
        kill[commit_id_i] <= commit_kill_i;
      end
      // The accepted record consumes its table slot; this overrides a same-cycle table write
      if (accept) begin
        seen[ex_id_i] <= 1'b0;
        kill[ex_id_i] <= 1'b0;
      end
      if (mem_result_valid_i && !mr_hit) err <= 1'b1;
    end
  end

  // Entry storage; validity is defined by head/count, so no reset is needed here
  always_ff @(posedge clk_i) begin
    if (enq) begin
      q_id[tail]        <= ex_id_i;
      q_rd[tail]        <= ex_rd_i;
      q_we[tail]        <= ex_gpr_we_i;
      q_xd[tail]        <= ex_xd_i;
      q_load[tail]      <= ex_load_i;
      q_addr[tail]      <= ex_next_addr_i;
      q_mem_done[tail]  <= !ex_load_i;
      q_committed[tail] <= new_committed;
      q_killed[tail]    <= new_killed;
    end
    if (commit_valid_i && cm_hit) begin
      q_committed[cm_idx] <= 1'b1;
      q_killed[cm_idx]    <= commit_kill_i;
    end
    if (mem_result_valid_i && mr_hit) begin
      q_rdata[mr_idx]    <= mem_result_rdata_i;
      q_mem_done[mr_idx] <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fir_xifu_wb.sv
// Directed self-checking bench for fir_xifu_wb (default build, DEPTH=4).
module tb_fir_xifu_wb;
  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready, ex_gpr_we, ex_load;
  logic [3:0]  ex_id;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_xd;
  logic [31:0] ex_next_addr;
  logic        mem_valid;
  logic [3:0]  mem_id;
  logic [31:0] mem_rdata;
  logic        commit_valid, commit_kill;
  logic [3:0]  commit_id;
  logic        result_valid, result_ready, result_we;
  logic [3:0]  result_id;
  logic [4:0]  result_rd;
  logic [31:0] result_data;
  logic        xreg_we;
  logic [2:0]  xreg_addr;
  logic [31:0] xreg_wdata;
  logic [2:0]  pending;
  logic        err;

  int checks = 0;
  int errors = 0;

  fir_xifu_wb #(.DEPTH(4), .ID_W(4), .XLEN(32), .XREG_W(3)) dut (
    .clk_i(clk), .rst_i(rst),
    .ex_valid_i(ex_valid), .ex_ready_o(ex_ready), .ex_id_i(ex_id), .ex_rd_i(ex_rd),
    .ex_gpr_we_i(ex_gpr_we), .ex_xd_i(ex_xd), .ex_load_i(ex_load), .ex_next_addr_i(ex_next_addr),
    .mem_result_valid_i(mem_valid), .mem_result_id_i(mem_id), .mem_result_rdata_i(mem_rdata),
    .commit_valid_i(commit_valid), .commit_id_i(commit_id), .commit_kill_i(commit_kill),
    .result_valid_o(result_valid), .result_ready_i(result_ready), .result_id_o(result_id),
    .result_rd_o(result_rd), .result_we_o(result_we), .result_data_o(result_data),
    .xreg_we_o(xreg_we), .xreg_addr_o(xreg_addr), .xreg_wdata_o(xreg_wdata),
    .pending_o(pending), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ex_valid = 0; ex_id = 0; ex_rd = 0; ex_gpr_we = 0; ex_xd = 0; ex_load = 0; ex_next_addr = 0;
    mem_valid = 0; mem_id = 0; mem_rdata = 0;
    commit_valid = 0; commit_id = 0; commit_kill = 0;
  endtask

  task automatic ex(input logic [3:0] id, input logic [4:0] rd, input logic ld,
                    input logic [2:0] xd, input logic [31:0] addr);
    ex_valid = 1; ex_id = id; ex_rd = rd; ex_gpr_we = 1; ex_load = ld; ex_xd = xd; ex_next_addr = addr;
  endtask

  task automatic commit(input logic [3:0] id, input logic k);
    commit_valid = 1; commit_id = id; commit_kill = k;
  endtask

  // Advance to 1 time unit after the next rising edge; inputs are then set and settled with #1
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1; result_ready = 0;
    cyc(); cyc();
    rst = 0; #1;
    chk("rst_ex_ready", 32'(ex_ready), 1);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_result_valid", 32'(result_valid), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_xreg_we", 32'(xreg_we), 0);

    // Non-load id=3 committed in the enqueue cycle
    cyc();
    result_ready = 1;
    ex(4'd3, 5'd5, 1'b0, 3'd0, 32'h1004); commit(4'd3, 1'b0); #1;
    chk("t1_no_same_cycle", 32'(result_valid), 0);
    cyc(); idle(); #1;
    chk("t1_valid", 32'(result_valid), 1);
    chk("t1_data", result_data, 32'h1004);
    chk("t1_id", 32'(result_id), 3);
    chk("t1_rd", 32'(result_rd), 5);
    chk("t1_we", 32'(result_we), 1);
    chk("t1_xreg_we", 32'(xreg_we), 0);
    cyc(); #1;
    chk("t1_pending_after", 32'(pending), 0);
    chk("t1_valid_after", 32'(result_valid), 0);

    // Load id=5, xd=2: commit at N+2, memory data at N+4, retire at N+5
    ex(4'd5, 5'd6, 1'b1, 3'd2, 32'h2000); #1;
    cyc(); idle(); #1;
    cyc(); commit(4'd5, 1'b0); #1;
    cyc(); idle(); #1;
    chk("t2_wait_mem", 32'(result_valid), 0);
    cyc(); mem_valid = 1; mem_id = 4'd5; mem_rdata = 32'hDEADBEEF; #1;
    chk("t2_no_result_yet", 32'(result_valid), 0);
    cyc(); idle(); #1;
    chk("t2_valid", 32'(result_valid), 1);
    chk("t2_data", result_data, 32'h2000);
    chk("t2_xreg_we", 32'(xreg_we), 1);
    chk("t2_xreg_addr", 32'(xreg_addr), 2);
    chk("t2_xreg_wdata", xreg_wdata, 32'hDEADBEEF);
    cyc(); #1;
    chk("t2_xreg_pulse_end", 32'(xreg_we), 0);
    chk("t2_pending", 32'(pending), 0);

    // Early commit for id=7 lands in the table; record arrives two cycles later
    commit(4'd7, 1'b0); #1;
    cyc(); idle(); #1;
    cyc(); ex(4'd7, 5'd7, 1'b0, 3'd0, 32'h3000); #1;
    cyc(); ex(4'd7, 5'd8, 1'b0, 3'd0, 32'h3100); #1;
    chk("t3_valid", 32'(result_valid), 1);
    chk("t3_data", result_data, 32'h3000);
    cyc(); idle(); #1;
    chk("t3_enq_pop_pending", 32'(pending), 1);
    chk("t3_slot_cleared", 32'(result_valid), 0);
    commit(4'd7, 1'b0); #1;
    cyc(); idle(); #1;
    chk("t3_live_commit_valid", 32'(result_valid), 1);
    chk("t3_live_commit_data", result_data, 32'h3100);
    chk("t3_live_commit_rd", 32'(result_rd), 8);
    cyc(); #1;

    // Fill all four entries with the core stalled
    result_ready = 0;
    for (int i = 0; i < 4; i++) begin
      ex(4'(10 + i), 5'(i), 1'b0, 3'd0, 32'h4000 + 32'(i)); commit(4'(10 + i), 1'b0); #1;
      cyc();
    end
    idle(); #1;
    chk("t4_full_pending", 32'(pending), 4);
    chk("t4_full_ready", 32'(ex_ready), 0);
    chk("t4_stall_valid", 32'(result_valid), 1);
    result_ready = 1;
    ex(4'd14, 5'd0, 1'b0, 3'd0, 32'h4444); #1;
    chk("t4_ready_low_on_pop", 32'(ex_ready), 0);
    for (int i = 0; i < 4; i++) begin
      chk("t4_order_id", 32'(result_id), 32'(10 + i));
      chk("t4_order_data", result_data, 32'h4000 + 32'(i));
      cyc(); idle(); #1;
    end
    chk("t4_drained", 32'(pending), 0);

    // Killed load id=1 ahead of non-load id=2
    ex(4'd1, 5'd1, 1'b1, 3'd1, 32'h5100); commit(4'd1, 1'b1); #1;
    cyc(); ex(4'd2, 5'd2, 1'b0, 3'd0, 32'h5000); commit(4'd2, 1'b0); #1;
    cyc(); idle(); mem_valid = 1; mem_id = 4'd1; mem_rdata = 32'h1111; #1;
    chk("t5_blocked", 32'(result_valid), 0);
    cyc(); idle(); #1;
    chk("t5_drop_no_result", 32'(result_valid), 0);
    chk("t5_drop_no_xreg", 32'(xreg_we), 0);
    cyc(); #1;
    chk("t5_id2_valid", 32'(result_valid), 1);
    chk("t5_id2_id", 32'(result_id), 2);
    chk("t5_id2_data", result_data, 32'h5000);
    chk("t5_err_clear", 32'(err), 0);
    cyc(); #1;

    // Unmatched memory result, then reset mid-queue
    mem_valid = 1; mem_id = 4'd9; mem_rdata = 32'h9999; #1;
    cyc(); idle(); ex(4'd4, 5'd4, 1'b0, 3'd0, 32'h6000); #1;
    chk("t6_err_set", 32'(err), 1);
    cyc(); ex(4'd6, 5'd6, 1'b0, 3'd0, 32'h6100); #1;
    cyc(); idle(); #1;
    chk("t6_pending_before_rst", 32'(pending), 2);
    chk("t6_err_sticky", 32'(err), 1);
    commit(4'd4, 1'b0); rst = 1; #1;
    cyc(); idle(); rst = 0; #1;
    chk("t6_rst_pending", 32'(pending), 0);
    chk("t6_rst_valid", 32'(result_valid), 0);
    chk("t6_rst_err", 32'(err), 0);
    chk("t6_rst_ready", 32'(ex_ready), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
